// File: rtl/div_pkg.sv
// div_pkg: shared FSM encoding and default operand width for the sequential divider
package div_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step producing the next partial remainder and quotient bit
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);
  logic [WIDTH:0] shifted;
  // rem < divisor on entry, so the post-subtract remainder always fits WIDTH bits
  always_comb begin
    shifted  = {rem, msb};
    qbit     = shifted >= {1'b0, divisor};
    rem_next = qbit ? shifted[WIDTH-1:0] - divisor : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/div_unsigned_seq.sv
// div_unsigned_seq: multi-cycle restoring unsigned divider, one quotient bit per clock
module div_unsigned_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_next;
  logic [WIDTH-1:0] rem, dvd, dvs, rem_next;
  logic [CW-1:0] cnt;
  logic qbit, zero, last;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem),
    .msb(dvd[WIDTH-1]),
    .divisor(dvs),
    .rem_next(rem_next),
    .qbit(qbit)
  );
  assign last = cnt == LAST;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = b == '0 ? DONE : CALC;
      CALC:    if (last) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst_n ? state_next : IDLE;
  // dvd shifts the dividend out of its MSB while quotient bits enter at the LSB
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem  <= '0;
      dvd  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      q    <= '0;
      r    <= '0;
      zero <= 1'b0;
    end else if (state == IDLE && start) begin
      dvs  <= b;
      dvd  <= a;
      rem  <= '0;
      cnt  <= '0;
      zero <= b == '0;
      if (b == '0) begin
        q <= '1;
        r <= a;
      end
    end else if (state == CALC) begin
      rem <= rem_next;
      dvd <= {dvd[WIDTH-2:0], qbit};
      cnt <= cnt + 1'b1;
      if (last) begin
        q <= {dvd[WIDTH-2:0], qbit};
        r <= rem_next;
      end
    end
  end
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  assign div_by_zero = done & zero;
endmodule

// File: tb/tb_div_unsigned_seq.sv
// tb_div_unsigned_seq: directed, exhaustive and random division checked by a queued scoreboard
module tb_div_unsigned_seq;
  localparam int W = 4;
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           t;
  } exp_t;
  logic clk = 0, rst_n = 0, start = 0;
  logic [W-1:0] a = '0, b = '0, q, r;
  logic busy, done, div_by_zero;
  exp_t sb[$];
  int cyc = 0, tests = 0, fails = 0;
  bit mon_en = 0;
  div_unsigned_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .q(q), .r(r), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  // reference: plain integer division, divide-by-zero gives all-ones quotient and r=a
  task automatic do_div(input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      $display("FAIL busy_timeout: busy stuck at cycle %0d", cyc);
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "busy never dropped");
    end
    a = x;
    b = y;
    start = 1;
    e.q = y == 0 ? {W{1'b1}} : W'(x / y);
    e.r = y == 0 ? x : W'(x % y);
    e.z = y == 0;
    e.t = cyc + (y == 0 ? 1 : W + 1);
    sb.push_back(e);
    @(negedge clk);
    start = 0;
  endtask
  task automatic poke(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      logic exp_done;
      exp_done = sb.size() > 0 && sb[0].t == cyc;
      chk("busy", busy, sb.size() > 0);
      chk("done", done, exp_done);
      if (exp_done) begin
        chk("q", q, sb[0].q);
        chk("r", r, sb[0].r);
        chk("div_by_zero", div_by_zero, sb[0].z);
        void'(sb.pop_front());
      end else chk("dbz_idle", div_by_zero, 0);
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    mon_en = 1;
    do_div(15, 15);
    do_div(14, 10);
    do_div(13, 2);
    do_div(0, 15);
    do_div(9, 0);
    do_div(15, 3);
    @(negedge clk);
    poke(2, 1);
    do_div(12, 5);
    @(negedge clk);
    rst_n = 0;
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    chk("midrst_q", q, 0);
    chk("midrst_r", r, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    do_div(12, 5);
    for (int i = 0; i < 256; i++) do_div(W'(i >> W), W'(i));
    for (int i = 0; i < 150; i++) begin
      do_div(W'($urandom), W'($urandom_range(0, 3) == 0 ? 0 : $urandom));
      if ($urandom_range(0, 2) == 0) poke(W'($urandom), W'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int n = 0; n < 50 && sb.size() > 0; n++) @(negedge clk);
    chk("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
